// File: rtl/pwm_multi_generator_if.sv
// Bus bundle for the multi-channel PWM generator: shadow-write port, global
// controls, and the counter/update/PWM outputs.
interface pwm_multi_generator_if #(
    parameter int N_CH       = 16,
    parameter int CNT_WIDTH  = 9,
    parameter int DATA_WIDTH = 8
);
    localparam int AW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                  sync;
    logic                  we;
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] wduty;
    logic [DATA_WIDTH-1:0] wphase;
    logic [CNT_WIDTH-1:0]  duty_offset;
    logic                  out_en;
    logic [CNT_WIDTH-1:0]  cyc_time;
    logic                  update;
    logic [N_CH-1:0]       pwm_out;

    modport master (
        output sync, we, addr, wduty, wphase, duty_offset, out_en,
        input  cyc_time, update, pwm_out
    );

    modport slave (
        input  sync, we, addr, wduty, wphase, duty_offset, out_en,
        output cyc_time, update, pwm_out
    );
endinterface

// File: rtl/pwm_multi_generator.sv
// Multi-channel double-buffered PWM generator: shared period counter, shadow
// duty/phase registers committed atomically at each wrap, registered outputs.
module pwm_multi_generator #(
    parameter int N_CH       = 16,
    parameter int CNT_WIDTH  = 9,
    parameter int CYCLE      = 512,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pwm_multi_generator_if.slave  bus
);
    localparam int AW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int SH = CNT_WIDTH - DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] TIME_LAST = CNT_WIDTH'(CYCLE - 1);
    localparam logic [CNT_WIDTH:0]   CYCLE_W   = (CNT_WIDTH + 1)'(CYCLE);
    localparam logic [AW:0]          N_CH_W    = (AW + 1)'(N_CH);

    logic [CNT_WIDTH-1:0]  time_q, time_d;
    logic [N_CH-1:0]       pwm_q, pwm_d;
    logic [DATA_WIDTH-1:0] sh_duty_q  [N_CH];
    logic [DATA_WIDTH-1:0] sh_duty_d  [N_CH];
    logic [DATA_WIDTH-1:0] sh_phase_q [N_CH];
    logic [DATA_WIDTH-1:0] sh_phase_d [N_CH];
    logic [DATA_WIDTH-1:0] act_duty_q [N_CH];
    logic [DATA_WIDTH-1:0] act_duty_d [N_CH];
    logic [DATA_WIDTH-1:0] act_phase_q[N_CH];
    logic [DATA_WIDTH-1:0] act_phase_d[N_CH];

    logic                  wrap_s;
    logic [CNT_WIDTH:0]    t_s;
    logic [CNT_WIDTH:0]    r_s    [N_CH];
    logic [CNT_WIDTH:0]    wraw_s [N_CH];
    logic [CNT_WIDTH:0]    w_s    [N_CH];
    logic [CNT_WIDTH:0]    d_s    [N_CH];

    // Period counter; SYNC restarts the period and counts as a wrap.
    always_comb begin
        wrap_s = bus.sync | (time_q == TIME_LAST);
        if (wrap_s) begin
            time_d = '0;
        end else begin
            time_d = time_q + CNT_WIDTH'(1);
        end
    end

    // Shadow writes and commit; commit takes the pre-edge shadow, so a write on
    // the commit edge waits for the following wrap.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            sh_duty_d[i]  = sh_duty_q[i];
            sh_phase_d[i] = sh_phase_q[i];
            if (wrap_s) begin
                act_duty_d[i]  = sh_duty_q[i];
                act_phase_d[i] = sh_phase_q[i];
            end else begin
                act_duty_d[i]  = act_duty_q[i];
                act_phase_d[i] = act_phase_q[i];
            end
        end
        if (bus.we && ({1'b0, bus.addr} < N_CH_W)) begin
            sh_duty_d[bus.addr]  = bus.wduty;
            sh_phase_d[bus.addr] = bus.wphase;
        end else begin
            sh_duty_d[0]  = sh_duty_q[0];
            sh_phase_d[0] = sh_phase_q[0];
        end
    end

    // Per-channel compare: distance from the phase start against saturated width.
    always_comb begin
        t_s = {1'b0, time_q};
        for (int i = 0; i < N_CH; i++) begin
            r_s[i]    = (CNT_WIDTH + 1)'(act_phase_q[i]) << SH;
            wraw_s[i] = ((CNT_WIDTH + 1)'(act_duty_q[i]) << SH)
                        + {1'b0, bus.duty_offset};
            if (wraw_s[i] > CYCLE_W) begin
                w_s[i] = CYCLE_W;
            end else begin
                w_s[i] = wraw_s[i];
            end
            if (t_s < r_s[i]) begin
                d_s[i] = t_s + CYCLE_W - r_s[i];
            end else begin
                d_s[i] = t_s - r_s[i];
            end
            pwm_d[i] = bus.out_en & (d_s[i] < w_s[i]);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_q <= '0;
            pwm_q  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                sh_duty_q[i]   <= '0;
                sh_phase_q[i]  <= '0;
                act_duty_q[i]  <= '0;
                act_phase_q[i] <= '0;
            end
        end else begin
            time_q <= time_d;
            pwm_q  <= pwm_d;
            for (int i = 0; i < N_CH; i++) begin
                sh_duty_q[i]   <= sh_duty_d[i];
                sh_phase_q[i]  <= sh_phase_d[i];
                act_duty_q[i]  <= act_duty_d[i];
                act_phase_q[i] <= act_phase_d[i];
            end
        end
    end

    assign bus.cyc_time = time_q;
    assign bus.update   = (time_q == TIME_LAST);
    assign bus.pwm_out  = pwm_q;
endmodule

// File: tb/tb_pwm_multi_generator.sv
// Scoreboard bench for pwm_multi_generator: a cycle model pushes expected
// outputs before each edge; they are popped and compared after the edge.
module tb_pwm_multi_generator;
    localparam int N  = 16;
    localparam int CW = 9;
    localparam int CY = 512;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    pwm_multi_generator_if #(.N_CH(N), .CNT_WIDTH(CW), .DATA_WIDTH(DW)) bus_if ();

    pwm_multi_generator #(.N_CH(N), .CNT_WIDTH(CW), .CYCLE(CY), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int m_time;
    int sh_d[N], sh_p[N], ac_d[N], ac_p[N];
    int last_t;
    int hi_cnt[N], lo_first[N], lo_last[N];
    logic [N-1:0] exp_pwm_q[$];
    int           exp_time_q[$];

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_bit(int duty, int phase, int off, int t, logic en);
        int w, r, d;
        w = duty * 2 + off;
        if (w > CY) w = CY;
        r = phase * 2;
        d = (((t - r) % CY) + CY) % CY;
        return en && (d < w);
    endfunction

    task automatic model_reset();
        m_time = 0;
        for (int i = 0; i < N; i++) begin
            sh_d[i] = 0; sh_p[i] = 0; ac_d[i] = 0; ac_p[i] = 0;
        end
        exp_pwm_q.delete();
        exp_time_q.delete();
    endtask

    task automatic tick();
        logic [N-1:0] e;
        logic [N-1:0] got;
        bit wrap;
        for (int i = 0; i < N; i++)
            e[i] = exp_bit(ac_d[i], ac_p[i], int'(bus_if.duty_offset), m_time, bus_if.out_en);
        exp_pwm_q.push_back(e);
        wrap = bus_if.sync || (m_time == CY - 1);
        if (wrap) begin
            for (int i = 0; i < N; i++) begin
                ac_d[i] = sh_d[i];
                ac_p[i] = sh_p[i];
            end
        end
        if (bus_if.we) begin
            sh_d[bus_if.addr] = int'(bus_if.wduty);
            sh_p[bus_if.addr] = int'(bus_if.wphase);
        end
        last_t = m_time;
        m_time = wrap ? 0 : m_time + 1;
        exp_time_q.push_back(m_time);
        @(posedge clk);
        #1;
        got = bus_if.pwm_out;
        chk_eq("pwm_out", got, exp_pwm_q.pop_front());
        chk_eq("time", bus_if.cyc_time, exp_time_q.pop_front());
        chk_eq("update", bus_if.update, (m_time == CY - 1));
        for (int i = 0; i < N; i++) begin
            if (got[i]) begin
                hi_cnt[i]++;
            end else begin
                if (lo_first[i] < 0) lo_first[i] = last_t;
                lo_last[i] = last_t;
            end
        end
        bus_if.sync = 1'b0;
        bus_if.we   = 1'b0;
    endtask

    task automatic wr(input int ch, input int duty, input int phase);
        bus_if.we     = 1'b1;
        bus_if.addr   = 4'(ch);
        bus_if.wduty  = 8'(duty);
        bus_if.wphase = 8'(phase);
        tick();
    endtask

    task automatic run_to(input int t);
        int n;
        n = 0;
        while (m_time != t && n < 1100) begin
            tick();
            n++;
        end
        if (m_time != t) chk_eq("run_to_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_period();
        for (int i = 0; i < N; i++) begin
            hi_cnt[i] = 0; lo_first[i] = -1; lo_last[i] = -1;
        end
        repeat (CY) tick();
    endtask

    initial begin
        bus_if.sync        = 1'b0;
        bus_if.we          = 1'b0;
        bus_if.addr        = 4'd0;
        bus_if.wduty       = 8'd0;
        bus_if.wphase      = 8'd0;
        bus_if.duty_offset = 9'd0;
        bus_if.out_en      = 1'b0;
        model_reset();
        #3;
        chk_eq("rst_time", bus_if.cyc_time, 32'd0);
        chk_eq("rst_pwm", bus_if.pwm_out, 32'd0);
        chk_eq("rst_update", bus_if.update, 32'd0);
        #5 rst_n = 1'b1;

        // Full-width pulse with phase, and a pulse wrapping across the boundary.
        bus_if.duty_offset = 9'd1;
        bus_if.out_en      = 1'b1;
        wr(0, 255, 50);
        wr(1, 250, 200);
        run_to(0);
        run_period();
        chk_eq("ch0_hi_cnt", hi_cnt[0], 32'd511);
        chk_eq("ch0_low_t", lo_first[0], 32'd99);
        chk_eq("ch1_hi_cnt", hi_cnt[1], 32'd501);
        chk_eq("ch1_low_first", lo_first[1], 32'd389);
        chk_eq("ch1_low_last", lo_last[1], 32'd399);

        // Width limits: zero and saturated.
        wr(3, 0, 0);
        bus_if.duty_offset = 9'd0;
        run_to(0);
        run_period();
        chk_eq("ch3_const_low", hi_cnt[3], 32'd0);
        wr(3, 255, 0);
        bus_if.duty_offset = 9'd2;
        run_to(0);
        run_period();
        chk_eq("ch3_const_high", hi_cnt[3], 32'd512);

        // Mid-period write, then a write landing on the commit edge.
        run_to(100);
        wr(2, 128, 0);
        run_to(511);
        wr(2, 10, 0);
        run_period();
        chk_eq("ch2_first_commit", hi_cnt[2], 32'd258);
        run_period();
        chk_eq("ch2_late_write", hi_cnt[2], 32'd22);

        // SYNC restart mid-period.
        wr(4, 100, 0);
        run_to(300);
        chk_eq("sync_pre_update", bus_if.update, 32'd0);
        bus_if.sync = 1'b1;
        tick();
        chk_eq("sync_time0", bus_if.cyc_time, 32'd0);
        chk_eq("sync_update", bus_if.update, 32'd0);
        run_period();
        chk_eq("ch4_sync_commit", hi_cnt[4], 32'd202);

        // Asynchronous reset mid-period with outputs high.
        run_to(250);
        chk_eq("pre_rst_ch0_high", bus_if.pwm_out[0], 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk_eq("async_rst_pwm", bus_if.pwm_out, 32'd0);
        chk_eq("async_rst_time", bus_if.cyc_time, 32'd0);
        model_reset();
        #2 rst_n = 1'b1;

        // Output enable forces all channels low from the next edge.
        wr(0, 255, 0);
        run_to(0);
        run_to(10);
        chk_eq("en_ch0_high", bus_if.pwm_out[0], 32'd1);
        bus_if.out_en = 1'b0;
        tick();
        chk_eq("out_en_low", bus_if.pwm_out, 32'd0);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
